prog_loader: RTL and testbench
==============================

# prog_loader

- Host-side program loader for the 8-bit processor.
- Accepts a framed byte stream on a valid/ready handshake and writes the payload into program RAM through the RAM write port: write enable, address, data.
- Holds the CPU in reset during the load and releases it only after the frame checksum verifies.
- Sits beside the CPU at top level; the top-level RAM port mux selects the loader whenever `cpu_rst` is high.

## Interface
Parameters:
- `BASE` — 8'h00 — RAM address of the first payload byte.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  single-cycle pulse; begin a new load. Honoured only in RUN or ERR.
- `in_valid`  in  1  host byte valid
- `in_data`  in  8  host byte
- `in_ready`  out  1  loader accepts `in_data` this cycle
- `mem_wren`  out  1  RAM write strobe
- `mem_addr`  out  8  RAM address
- `mem_data`  out  8  RAM write data
- `cpu_rst`  out  1  CPU reset hold, active-high
- `busy`  out  1  load frame in progress
- `err`  out  1  last frame failed its checksum; sticky until `start` or `rst`

## Operation
Frame format:
- Byte 0 is LEN.
  - N = LEN, except LEN = 0 means N = 256.
- Next come N payload bytes.
- Last comes CSUM = (sum of payload bytes) mod 256.

Handshake:
- A byte transfers when `in_valid && in_ready` are both high at a rising edge.
- `in_data` is ignored when no transfer occurs.

States:
- LEN
  - `in_ready`=1.
  - On transfer: latch N into a 9-bit remaining counter, clear the sum, set addr ← BASE, go to DATA.
- DATA
  - `in_ready`=1.
  - On transfer: issue a write of the byte at addr, addr ← addr+1 (mod 256), sum ← sum+byte (mod 256), remaining−1.
  - When remaining reaches 0 after this transfer, go to CSUM.
- CSUM
  - `in_ready`=1.
  - On transfer: if the byte equals sum, go to RUN; otherwise go to ERR.
- RUN
  - `in_ready`=0, `cpu_rst`=0.
  - `start` → LEN.
- ERR
  - `in_ready`=0, `cpu_rst`=1, `err`=1.
  - `start` → LEN, which clears `err`.

Output rules:
- `busy` = 1 in LEN, DATA and CSUM.
- `cpu_rst` = 1 in every state except RUN.
- `start` is ignored in LEN, DATA and CSUM.
- Address wraps from 8'hFF to 8'h00; N=256 overwrites the entire RAM.
- `mem_addr` and `mem_data` hold their last values when `mem_wren`=0.

## Timing
- Reset values:
  - state = LEN
  - `in_ready`=1, `busy`=1, `cpu_rst`=1
  - `err`=0, `mem_wren`=0
  - `mem_addr`=BASE, `mem_data`=0
- Reset asserted mid-frame aborts the load.
  - Bytes already written stay in RAM.
  - The next accepted byte is treated as a new LEN.
- Payload byte accepted at edge k: `mem_wren`=1, `mem_addr`, `mem_data` are valid from edge k to edge k+1. The write strobe is exactly one cycle wide.
- Back-to-back transfers give one write per cycle, with no bubbles.
- CSUM accepted at edge k:
  - State becomes RUN or ERR at edge k.
  - `cpu_rst` falls (or `err` rises) at edge k, since all outputs are registered.
  - The final payload write is at least one cycle earlier, so RAM is complete before the CPU leaves reset.
- `start` sampled at edge k in RUN: `cpu_rst`=1 and `in_ready`=1 from edge k.
- `start` coinciding with `rst`: reset wins.

## Structure
- Package `loader_pkg`:
  - `loader_state_t` enum {LEN, DATA, CSUM, RUN, ERR}
  - constants `LEN_FULL`=9'd256 and `ADDR_W`=8
- A single module `prog_loader` implements the block; no sub-module is needed.
- Counter, sum, address and output registers all live in one `always_ff`; next-state logic goes in `always_comb`.

## Test plan
- Basic load, BASE=0: bytes 03, 11, 22, 33, 66.
  - Writes 11@00, 22@01, 33@02 in three consecutive cycles.
  - `cpu_rst` falls at the CSUM edge; `err`=0; `in_ready`=0.
- Bad checksum: bytes 02, 10, 20, 31.
  - Both writes occur; state goes to ERR; `err`=1; `cpu_rst` stays 1.
  - A `start` pulse clears `err` and sets `in_ready`=1.
- Full RAM with BASE=8'hF0: LEN=00, then 256 bytes of value i, then CSUM 80.
  - Address runs F0…FF, then 00…EF.
  - Result: RUN.
- Handshake stalls: `in_valid` toggles 1/0 randomly during a 4-byte frame.
  - Exactly 4 writes occur, with contents and addresses matching the gap-free case.
- Reset mid-DATA: assert `rst` after 2 of 5 payload bytes.
  - Outputs return to reset values next edge.
  - The following frame 01, AA, AA writes AA@BASE and reaches RUN.
- `start` during DATA is ignored; the frame completes normally.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the host-side program loader.
//   loader_state_t : frame-parsing state
//   ADDR_W/DATA_W  : RAM address / data widths
//   CNT_W          : payload counter width (must hold 256)
//   LEN_FULL       : payload length encoded by a LEN byte of zero
package loader_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 9;

  localparam logic [CNT_W-1:0] LEN_FULL = 9'd256;

  typedef enum logic [2:0] {
    LEN,
    DATA,
    CSUM,
    RUN,
    ERR
  } loader_state_t;

  // True while a frame is being received.
  function automatic logic is_loading(input loader_state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (LEN, N payload bytes, CSUM)
// over valid/ready, writes the payload into program RAM starting at BASE and
// holds the CPU in reset until the frame checksum verifies.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, begins a new load from RUN or ERR
//   in_valid/in_data  : host byte stream
//   in_ready          : loader accepts a byte this cycle
//   mem_wren/addr/data: RAM write port (addr/data hold when not writing)
//   cpu_rst           : CPU reset hold, low only after a verified frame
//   busy              : frame reception in progress
//   err               : last frame failed its checksum (sticky)
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              err
);

  loader_state_t      state;
  loader_state_t      state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [DATA_W-1:0]  sum;
  logic [ADDR_W-1:0]  wr_ptr;

  logic               xfer_c;
  logic [CNT_W-1:0]   len_n_c;

  // Handshake decode and next-state selection.
  always_comb begin
    xfer_c    = in_valid && in_ready;
    len_n_c   = (in_data == '0) ? LEN_FULL : CNT_W'(in_data);
    state_nxt = state;
    case (state)
      LEN:  if (xfer_c) state_nxt = DATA;
      DATA: if (xfer_c && (remaining == CNT_W'(1))) state_nxt = CSUM;
      CSUM: if (xfer_c) state_nxt = (in_data == sum) ? RUN : ERR;
      RUN:  if (start) state_nxt = LEN;
      ERR:  if (start) state_nxt = LEN;
      default: state_nxt = LEN;
    endcase
  end

  // Datapath and registered outputs; outputs follow the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LEN;
      remaining <= '0;
      sum       <= '0;
      wr_ptr    <= BASE;
      mem_wren  <= 1'b0;
      mem_addr  <= BASE;
      mem_data  <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b1;
      cpu_rst   <= 1'b1;
      err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_wren <= 1'b0;
      case (state)
        LEN: begin
          if (xfer_c) begin
            remaining <= len_n_c;
            sum       <= '0;
            wr_ptr    <= BASE;
          end
        end
        DATA: begin
          if (xfer_c) begin
            mem_wren  <= 1'b1;
            mem_addr  <= wr_ptr;
            mem_data  <= in_data;
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            sum       <= sum + in_data;
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
      in_ready <= is_loading(state_nxt);
      busy     <= is_loading(state_nxt);
      cpu_rst  <= (state_nxt != RUN);
      err      <= (state_nxt == ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (BASE=00 and BASE=F0) share stimulus.
// A cycle table covers exact timing; frame-level sequences are checked
// against expected write lists and checksum outcomes.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready0, mem_wren0, cpu_rst0, busy0, err0;
  logic [7:0] mem_addr0, mem_data0;
  logic       in_ready1, mem_wren1, cpu_rst1, busy1, err1;
  logic [7:0] mem_addr1, mem_data1;

  prog_loader #(.BASE(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .mem_wren(mem_wren0), .mem_addr(mem_addr0),
    .mem_data(mem_data0), .cpu_rst(cpu_rst0), .busy(busy0), .err(err0)
  );

  prog_loader #(.BASE(8'hF0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .mem_wren(mem_wren1), .mem_addr(mem_addr1),
    .mem_data(mem_data1), .cpu_rst(cpu_rst1), .busy(busy1), .err(err1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic rdy, input logic bsy,
                          input logic crst, input logic er, input logic wr);
    chk({tag, ".in_ready0"}, 32'(in_ready0), 32'(rdy));
    chk({tag, ".in_ready1"}, 32'(in_ready1), 32'(rdy));
    chk({tag, ".busy0"},     32'(busy0),     32'(bsy));
    chk({tag, ".busy1"},     32'(busy1),     32'(bsy));
    chk({tag, ".cpu_rst0"},  32'(cpu_rst0),  32'(crst));
    chk({tag, ".cpu_rst1"},  32'(cpu_rst1),  32'(crst));
    chk({tag, ".err0"},      32'(err0),      32'(er));
    chk({tag, ".err1"},      32'(err1),      32'(er));
    chk({tag, ".mem_wren0"}, 32'(mem_wren0), 32'(wr));
    chk({tag, ".mem_wren1"}, 32'(mem_wren1), 32'(wr));
  endtask

  // Expected RAM writes in order, per instance address.
  logic       mon_en = 1'b0;
  logic [7:0] exp_a0[$];
  logic [7:0] exp_a1[$];
  logic [7:0] exp_d[$];

  always @(negedge clk) begin
    if (mon_en && (mem_wren0 || mem_wren1)) begin
      if (exp_d.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr0=%0h data0=%0h wren=%b%b required no write",
                 mem_addr0, mem_data0, mem_wren0, mem_wren1);
      end else begin
        logic [7:0] a0, a1, d;
        a0 = exp_a0.pop_front();
        a1 = exp_a1.pop_front();
        d  = exp_d.pop_front();
        chk("wr_pair",  32'({mem_wren0, mem_wren1}), 32'(2'b11));
        chk("wr_addr0", 32'(mem_addr0), 32'(a0));
        chk("wr_addr1", 32'(mem_addr1), 32'(a1));
        chk("wr_data0", 32'(mem_data0), 32'(d));
        chk("wr_data1", 32'(mem_data1), 32'(d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input int off, input logic [7:0] d);
    exp_a0.push_back(8'(off));
    exp_a1.push_back(8'(32'hF0 + off));
    exp_d.push_back(d);
  endtask

  // Offer one byte, optionally after random idle cycles, until accepted.
  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    int   waited;
    logic r;
    waited = 0;
    while (stall_pct > 0 && int'($urandom_range(99, 0)) < stall_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (1) begin
      r = in_ready0;
      tick();
      if (r) break;
      waited++;
      if (waited > 50) begin
        checks++;
        failures++;
        $display("FAIL handshake_timeout: got in_ready=0 for %0d cycles required 1", waited);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] payload[$], input logic [7:0] csum,
                            input int stall_pct);
    send_byte(8'(payload.size()), stall_pct);
    foreach (payload[i]) begin
      expect_write(i, payload[i]);
      send_byte(payload[i], stall_pct);
    end
    send_byte(csum, stall_pct);
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] payload[$]);
    int s;
    s = 0;
    foreach (payload[i]) s += int'(payload[i]);
    return 8'(s % 256);
  endfunction

  // Called right after the checksum edge.
  task automatic expect_outcome(input string tag, input logic ok);
    chk({tag, ".writes_left"}, 32'(exp_d.size()), 32'd0);
    exp_a0.delete();
    exp_a1.delete();
    exp_d.delete();
    chk_ctrl(tag, 1'b0, 1'b0, !ok, !ok, 1'b0);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_ctrl(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       rst, start, valid;
    logic [7:0] data;
    logic       rdy, bsy, crst, er, wr;
    logic [7:0] off, wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [7:0] d,
                              input logic rdy, input logic bsy, input logic crst, input logic er,
                              input logic wr, input logic [7:0] off, input logic [7:0] wd);
    vec_t x;
    x.rst = r; x.start = s; x.valid = v; x.data = d;
    x.rdy = rdy; x.bsy = bsy; x.crst = crst; x.er = er; x.wr = wr;
    x.off = off; x.wdata = wd;
    return x;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pl[$];
    int n;
    logic ok;
    logic [7:0] cs;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    //            rst st  v  data  rdy bsy crst err wr off  wdata
    vecs.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 8'h00)); // reset
    vecs.push_back(mk(0, 0, 1, 8'h03, 1, 1, 1, 0, 0, 8'h00, 8'h00)); // LEN=3
    vecs.push_back(mk(0, 0, 1, 8'h11, 1, 1, 1, 0, 1, 8'h00, 8'h11));
    vecs.push_back(mk(0, 0, 1, 8'h22, 1, 1, 1, 0, 1, 8'h01, 8'h22));
    vecs.push_back(mk(0, 0, 1, 8'h33, 1, 1, 1, 0, 1, 8'h02, 8'h33));
    vecs.push_back(mk(0, 0, 1, 8'h66, 0, 0, 0, 0, 0, 8'h02, 8'h33)); // good csum
    vecs.push_back(mk(0, 0, 1, 8'h55, 0, 0, 0, 0, 0, 8'h02, 8'h33)); // ignored
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h02, 8'h33)); // start
    vecs.push_back(mk(0, 0, 1, 8'h02, 1, 1, 1, 0, 0, 8'h02, 8'h33)); // LEN=2
    vecs.push_back(mk(0, 1, 1, 8'h10, 1, 1, 1, 0, 1, 8'h00, 8'h10)); // start ignored
    vecs.push_back(mk(0, 0, 1, 8'h20, 1, 1, 1, 0, 1, 8'h01, 8'h20));
    vecs.push_back(mk(0, 0, 1, 8'h31, 0, 0, 1, 1, 0, 8'h01, 8'h20)); // bad csum
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h01, 8'h20)); // err sticky
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h01, 8'h20)); // start clears
    vecs.push_back(mk(0, 0, 1, 8'h01, 1, 1, 1, 0, 0, 8'h01, 8'h20));
    vecs.push_back(mk(0, 0, 1, 8'hAA, 1, 1, 1, 0, 1, 8'h00, 8'hAA));
    vecs.push_back(mk(0, 0, 1, 8'h55, 0, 0, 1, 1, 0, 8'h00, 8'hAA)); // bad csum
    vecs.push_back(mk(1, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 8'h00)); // reset wins

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      rst = vecs[i].rst; start = vecs[i].start;
      in_valid = vecs[i].valid; in_data = vecs[i].data;
      tick();
      chk_ctrl(tag, vecs[i].rdy, vecs[i].bsy, vecs[i].crst, vecs[i].er, vecs[i].wr);
      chk({tag, ".mem_addr0"}, 32'(mem_addr0), 32'(vecs[i].off));
      chk({tag, ".mem_addr1"}, 32'(mem_addr1), 32'(8'(32'hF0 + 32'(vecs[i].off))));
      chk({tag, ".mem_data0"}, 32'(mem_data0), 32'(vecs[i].wdata));
      chk({tag, ".mem_data1"}, 32'(mem_data1), 32'(vecs[i].wdata));
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    mon_en = 1'b1;

    // Full RAM: 256 bytes of value i, wrapping address.
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    send_frame(pl, 8'h80, 0);
    expect_outcome("full_ram", 1'b1);
    pulse_start("full_ram_start");

    // Four-byte frame with random valid gaps.
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
    send_frame(pl, sum8(pl), 50);
    expect_outcome("stall4", 1'b1);
    pulse_start("stall4_start");

    // start asserted during DATA has no effect.
    pl.delete();
    pl.push_back(8'h5A); pl.push_back(8'hC3); pl.push_back(8'h01);
    send_byte(8'h03, 0);
    expect_write(0, pl[0]);
    send_byte(pl[0], 0);
    start = 1'b1;
    expect_write(1, pl[1]);
    send_byte(pl[1], 0);
    start = 1'b0;
    expect_write(2, pl[2]);
    send_byte(pl[2], 0);
    send_byte(sum8(pl), 0);
    expect_outcome("start_in_data", 1'b1);
    pulse_start("start_in_data_start");

    // Reset after two of five payload bytes, then a fresh one-byte frame.
    send_byte(8'h05, 0);
    expect_write(0, 8'h12); send_byte(8'h12, 0);
    expect_write(1, 8'h34); send_byte(8'h34, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst.writes_left", 32'(exp_d.size()), 32'd0);
    chk_ctrl("mid_rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_rst.mem_addr0", 32'(mem_addr0), 32'h00);
    chk("mid_rst.mem_addr1", 32'(mem_addr1), 32'hF0);
    chk("mid_rst.mem_data0", 32'(mem_data0), 32'h00);
    pl.delete();
    pl.push_back(8'hAA);
    send_frame(pl, 8'hAA, 0);
    expect_outcome("after_rst", 1'b1);
    pulse_start("after_rst_start");

    // Random frames, some with corrupted checksums.
    for (int f = 0; f < 20; f++) begin
      pl.delete();
      n = int'($urandom_range(24, 1));
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      ok = ($urandom_range(99, 0) >= 30);
      cs = sum8(pl);
      if (!ok) cs = cs + 8'($urandom_range(255, 1));
      send_frame(pl, cs, ($urandom_range(1, 0) == 1) ? 40 : 0);
      expect_outcome($sformatf("rand%0d", f), ok);
      pulse_start($sformatf("rand%0d_start", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
